// File: rtl/mac_tx_framer.sv
// mac_tx_framer: 256-bit packet stream to 4x64 PCS lanes.
// Adds preamble/SFD, shifts payload by one lane, places terminate.
module mac_tx_framer #(
  parameter int LANE_N = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [LANE_N*DATA_W-1:0]   s_data_i,
  input  logic [LANE_N*KEEP_W-1:0]   s_keep_i,
  input  logic                       s_last_i,
  input  logic                       s_err_i,
  input  logic                       pcs_ready_i,
  output logic [LANE_N-1:0]          ctrl_v_o,
  output logic [LANE_N-1:0]          idle_v_o,
  output logic [LANE_N-1:0]          start_v_o,
  output logic [LANE_N-1:0]          term_v_o,
  output logic [LANE_N-1:0]          err_v_o,
  output logic [LANE_N*DATA_W-1:0]   data_o,
  output logic [LANE_N*KEEP_W-1:0]   keep_o
);

  localparam logic [63:0] PRE = 64'hD555_5555_5555_55FB;

  typedef enum logic [1:0] {
    IDLE, DATA, FLUSH, DROP
  } state_t;

  state_t        state_q, state_d;
  logic          gap_q, gap_d;
  logic [63:0]   res_q, res_d;
  logic [3:0]    fk_q, fk_d;
  logic          ferr_q, ferr_d;

  logic [3:0]    ctrl_d, idle_d, start_d, term_d, err_d;
  logic [255:0]  data_d;
  logic [31:0]   keep_d;

  logic [255:0]  w;
  logic [5:0]    nb;
  logic [5:0]    k;
  logic [2:0]    t;
  logic          fin, lerr, emit, start, fire;

  assign k = 6'($countones(s_keep_i));
  assign fire = s_valid_i & s_ready_o;
  assign s_ready_o = pcs_ready_i &
    ((state_q == IDLE & ~gap_q) |
     state_q == DATA | state_q == DROP);

  // next state and next output word
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    res_d   = res_q;
    fk_d    = fk_q;
    ferr_d  = ferr_q;
    ctrl_d  = '1;
    idle_d  = '1;
    start_d = '0;
    term_d  = '0;
    err_d   = '0;
    data_d  = '0;
    keep_d  = '0;
    w       = '0;
    nb      = 6'd32;
    t       = '0;
    fin     = 1'b0;
    lerr    = 1'b0;
    emit    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_d = 1'b0;
        if (fire) begin
          emit  = 1'b1;
          start = 1'b1;
          w     = {s_data_i[191:0], PRE};
        end
      end
      DATA: begin
        if (fire) begin
          emit = 1'b1;
          w    = {s_data_i[191:0], res_q};
        end else begin
          idle_d  = 4'hE;
          err_d   = 4'h1;
          state_d = DROP;
        end
      end
      FLUSH: begin
        emit    = 1'b1;
        fin     = 1'b1;
        w       = {192'd0, res_q};
        nb      = {2'b00, fk_q};
        lerr    = ferr_q;
        state_d = IDLE;
        gap_d   = 1'b1;
      end
      DROP: begin
        if (fire && s_last_i) begin
          state_d = IDLE;
          gap_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit && state_q != FLUSH) begin
      res_d   = s_data_i[255:192];
      state_d = DATA;
      if (s_last_i) begin
        if (k < 6'd24) begin
          fin     = 1'b1;
          nb      = 6'd8 + k;
          lerr    = s_err_i;
          state_d = IDLE;
          gap_d   = 1'b1;
        end else begin
          state_d = FLUSH;
          fk_d    = 4'(k - 6'd24);
          ferr_d  = s_err_i;
        end
      end
    end
    if (emit) begin
      t = nb[5:3];
      for (int l = 0; l < 4; l++) begin
        if (!fin || 3'(l) < t) begin
          ctrl_d[l]          = 1'b0;
          idle_d[l]          = 1'b0;
          data_d[64*l +: 64] = w[64*l +: 64];
          keep_d[8*l +: 8]   = 8'hFF;
        end else if (3'(l) == t) begin
          idle_d[l] = 1'b0;
          if (lerr) begin
            err_d[l] = 1'b1;
          end else begin
            term_d[l] = 1'b1;
            for (int j = 0; j < 8; j++) begin
              if (3'(j) < nb[2:0]) begin
                keep_d[8*l+j] = 1'b1;
                data_d[64*l+8*j +: 8] = w[64*l+8*j +: 8];
              end
            end
          end
        end
      end
      if (start) begin
        ctrl_d[0]  = 1'b1;
        start_d[0] = 1'b1;
      end
    end
  end

  // state and output word advance only when the PCS takes a word
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      gap_q     <= 1'b1;
      res_q     <= '0;
      fk_q      <= '0;
      ferr_q    <= 1'b0;
      ctrl_v_o  <= '1;
      idle_v_o  <= '1;
      start_v_o <= '0;
      term_v_o  <= '0;
      err_v_o   <= '0;
      data_o    <= '0;
      keep_o    <= '0;
    end else if (pcs_ready_i) begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      res_q     <= res_d;
      fk_q      <= fk_d;
      ferr_q    <= ferr_d;
      ctrl_v_o  <= ctrl_d;
      idle_v_o  <= idle_d;
      start_v_o <= start_d;
      term_v_o  <= term_d;
      err_v_o   <= err_d;
      data_o    <= data_d;
      keep_o    <= keep_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: random frames vs a byte-stream lane model.
// Each test drives frames and checks the emitted word stream.
module tb_mac_tx_framer;

  logic         clk;
  logic         nreset;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [255:0] s_data_i;
  logic [31:0]  s_keep_i;
  logic         s_last_i;
  logic         s_err_i;
  logic         pcs_ready_i;
  logic [3:0]   ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
  logic [255:0] data_o;
  logic [31:0]  keep_o;

  typedef struct packed {
    logic [3:0]   c;
    logic [3:0]   i;
    logic [3:0]   s;
    logic [3:0]   t;
    logic [3:0]   e;
    logic [255:0] d;
    logic [31:0]  k;
  } word_t;

  word_t      obs[$];
  word_t      exp[$];
  logic [7:0] pay[$];
  bit         rec;
  int         total;
  int         bad;

  mac_tx_framer dut (
    .clk(clk), .nreset(nreset),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i),
    .s_last_i(s_last_i), .s_err_i(s_err_i),
    .pcs_ready_i(pcs_ready_i),
    .ctrl_v_o(ctrl_v_o), .idle_v_o(idle_v_o),
    .start_v_o(start_v_o), .term_v_o(term_v_o),
    .err_v_o(err_v_o), .data_o(data_o), .keep_o(keep_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t idle_w();
    word_t w;
    w   = '0;
    w.c = 4'hF;
    w.i = 4'hF;
    return w;
  endfunction

  function automatic word_t cur();
    word_t w;
    w.c = ctrl_v_o;
    w.i = idle_v_o;
    w.s = start_v_o;
    w.t = term_v_o;
    w.e = err_v_o;
    w.d = data_o;
    w.k = keep_o;
    return w;
  endfunction

  // record every word the PCS takes
  initial begin
    forever begin
      logic ld;
      @(posedge clk);
      ld = pcs_ready_i & nreset;
      #1;
      if (ld && rec) obs.push_back(cur());
    end
  end

  // lane model: preamble + payload bytes cut into 8-byte lanes
  task automatic model_frame(input bit err, input bit trunc);
    logic [7:0] b[$];
    word_t      w;
    int         n, tl, nw, lane;
    b = {8'hFB, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    foreach (pay[x]) b.push_back(pay[x]);
    n  = b.size();
    tl = n / 8;
    nw = trunc ? tl / 4 : tl / 4 + 1;
    for (int wi = 0; wi < nw; wi++) begin
      w = idle_w();
      for (int ln = 0; ln < 4; ln++) begin
        lane = wi * 4 + ln;
        if (lane < tl) begin
          w.c[ln] = (lane == 0);
          w.s[ln] = (lane == 0);
          w.i[ln] = 1'b0;
          w.k[8*ln +: 8] = 8'hFF;
          for (int j = 0; j < 8; j++)
            w.d[64*ln+8*j +: 8] = b[8*lane+j];
        end else if (lane == tl) begin
          w.i[ln] = 1'b0;
          if (err) begin
            w.e[ln] = 1'b1;
          end else begin
            w.t[ln] = 1'b1;
            for (int j = 0; j < n % 8; j++) begin
              w.k[8*ln+j] = 1'b1;
              w.d[64*ln+8*j +: 8] = b[8*lane+j];
            end
          end
        end
      end
      exp.push_back(w);
    end
    if (!trunc) exp.push_back(idle_w());
  endtask

  task automatic put_beat(input logic [255:0] d, input logic [31:0] km,
                          input logic l, input logic e, input int bp);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_keep_i  = km;
    s_last_i  = l;
    s_err_i   = e;
    while (!acc) begin
      pcs_ready_i = (bp == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp);
      #1;
      acc = s_ready_o;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!acc && n > 200) begin
        total++;
        bad++;
        $display("FAIL put_beat timeout got ready=0 want ready=1");
        acc = 1'b1;
      end
    end
  endtask

  task automatic freeze(input logic [255:0] d, input logic [31:0] km);
    word_t snap;
    s_valid_i   = 1'b1;
    s_data_i    = d;
    s_keep_i    = km;
    s_last_i    = 1'b0;
    s_err_i     = 1'b0;
    pcs_ready_i = 1'b0;
    snap = cur();
    repeat (3) begin
      #1;
      total++;
      if (s_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL freeze_ready got %b want 0", s_ready_o);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (cur() !== snap) begin
        bad++;
        $display("FAIL freeze_hold got d=%h want d=%h", data_o, snap.d);
      end
    end
  endtask

  task automatic send_frame(input int nbeats, input int lk, input bit err,
                            input int bp, input int frz, input int cut);
    logic [255:0] d;
    logic [32:0]  km;
    int           cnt;
    bit           last;
    pay.delete();
    for (int b = 0; b < nbeats; b++) begin
      last = (b == nbeats - 1);
      cnt  = last ? lk : 32;
      d  = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      km = (33'd1 << cnt) - 33'd1;
      if (b == frz) freeze(d, km[31:0]);
      if (b == cut) begin
        s_valid_i   = 1'b0;
        pcs_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
      put_beat(d, km[31:0], last, last & err, bp);
      if (cut < 0 || b < cut)
        for (int j = 0; j < cnt; j++) pay.push_back(d[8*j +: 8]);
    end
    if (cut < 0) begin
      model_frame(err, 1'b0);
    end else begin
      word_t ew;
      model_frame(1'b0, 1'b1);
      ew   = idle_w();
      ew.i = 4'hE;
      ew.e = 4'h1;
      exp.push_back(ew);
      for (int r = cut; r < nbeats; r++) exp.push_back(idle_w());
      exp.push_back(idle_w());
    end
  endtask

  task automatic prep();
    s_valid_i   = 1'b0;
    s_last_i    = 1'b0;
    s_err_i     = 1'b0;
    pcs_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    obs.delete();
    exp.delete();
    rec = 1'b1;
  endtask

  task automatic finish_stream(input string nm);
    int s;
    s_valid_i   = 1'b0;
    pcs_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    rec = 1'b0;
    s = 0;
    while (s < obs.size() && obs[s] == idle_w()) s++;
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (s + i >= obs.size()) begin
        bad++;
        $display("FAIL %s word %0d got none want c=%h", nm, i, exp[i].c);
      end else if (obs[s+i] !== exp[i]) begin
        bad++;
        $display("FAIL %s word %0d got c=%h i=%h s=%h t=%h e=%h k=%h d=%h want c=%h i=%h s=%h t=%h e=%h k=%h d=%h",
          nm, i, obs[s+i].c, obs[s+i].i, obs[s+i].s, obs[s+i].t,
          obs[s+i].e, obs[s+i].k, obs[s+i].d, exp[i].c, exp[i].i,
          exp[i].s, exp[i].t, exp[i].e, exp[i].k, exp[i].d);
      end
    end
  endtask

  task automatic test_reset();
    nreset      = 1'b0;
    s_valid_i   = 1'b0;
    pcs_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (cur() !== idle_w()) begin
      bad++;
      $display("FAIL reset_out got c=%h i=%h d=%h want c=f i=f d=0",
        ctrl_v_o, idle_v_o, data_o);
    end
    nreset = 1'b1;
    #1;
    total++;
    if (s_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got %b want 0", s_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL gap_clear got %b want 1", s_ready_o);
    end
  endtask

  task automatic test_single();
    prep();
    send_frame(1, 16, 1'b0, 0, -1, -1);
    send_frame(1, 16, 1'b0, 0, -1, -1);
    send_frame(1, 1, 1'b0, 0, -1, -1);
    finish_stream("single");
  endtask

  task automatic test_flush();
    prep();
    send_frame(2, 32, 1'b0, 0, -1, -1);
    send_frame(2, 27, 1'b0, 0, -1, -1);
    send_frame(2, 24, 1'b0, 0, -1, -1);
    send_frame(1, 32, 1'b0, 0, -1, -1);
    send_frame(2, 23, 1'b0, 0, -1, -1);
    finish_stream("flush");
  endtask

  task automatic test_back_pressure();
    prep();
    send_frame(4, 20, 1'b0, 0, 2, -1);
    send_frame(3, 30, 1'b0, 40, -1, -1);
    finish_stream("backpressure");
  endtask

  task automatic test_error();
    prep();
    send_frame(1, 5, 1'b1, 0, -1, -1);
    send_frame(2, 30, 1'b1, 0, -1, -1);
    send_frame(2, 32, 1'b1, 0, -1, -1);
    finish_stream("error");
  endtask

  task automatic test_underrun();
    prep();
    send_frame(4, 32, 1'b0, 0, -1, 2);
    send_frame(1, 10, 1'b0, 0, -1, -1);
    finish_stream("underrun");
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    prep();
    rec = 1'b0;
    d = {8{$urandom()}};
    put_beat(d, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    nreset    = 1'b0;
    s_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cur() !== idle_w()) begin
      bad++;
      $display("FAIL reset_mid got c=%h i=%h t=%h want c=f i=f t=0",
        ctrl_v_o, idle_v_o, term_v_o);
    end
    nreset = 1'b1;
  endtask

  task automatic test_random();
    prep();
    for (int f = 0; f < 25; f++)
      send_frame($urandom_range(1, 4), $urandom_range(1, 32),
                 ($urandom_range(0, 4) == 0), 30, -1, -1);
    finish_stream("random");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rec       = 1'b0;
    nreset    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_keep_i  = '0;
    s_last_i  = 1'b0;
    s_err_i   = 1'b0;
    pcs_ready_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_flush();
    test_back_pressure();
    test_error();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_tx_framer.md
# mac_tx_framer

Packet-to-lane framer feeding the 40GBASE-R PCS transmit path. Takes a 256-bit byte-stream packet interface (valid/ready, keep, last, err) and produces four 64-bit lanes of control flags, data and keep per cycle. Emits a start block with preamble/SFD on lane 0, shifts the payload by 8 bytes, places the terminate lane and fills idles. Honours PCS back-pressure from alignment-marker insertion and enforces a minimum one-cycle idle gap between frames.

## Interface
- LANE_N, 4: lane count; only 4 is supported.
- DATA_W, 64: bits per lane.
- KEEP_W, DATA_W/8: keep bits per lane.
- clk  in  1  PCS clock.
- nreset  in  1  reset; synchronous, active-low.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o.
- s_data_i  in  256  payload; byte 0 in bits [7:0].
- s_keep_i  in  32  byte enables; contiguous from bit 0; all ones except on the last beat; never zero.
- s_last_i  in  1  last beat of packet.
- s_err_i  in  1  sampled with s_last_i; marks the frame bad.
- pcs_ready_i  in  1  PCS consumes the current output word.
- ctrl_v_o  out  4  per-lane control-block flag.
- idle_v_o  out  4  per-lane idle.
- start_v_o  out  4  per-lane start; only bit 0 is ever set.
- term_v_o  out  4  per-lane terminate.
- err_v_o  out  4  per-lane error block.
- data_o  out  256  lane data, lane l in bits [64l+63:64l].
- keep_o  out  32  lane keep.

## Operation
- All outputs except s_ready_o are registered.
- The output register loads a new word only on edges where pcs_ready_i=1. Otherwise all outputs hold.
- s_ready_o is combinational: pcs_ready_i & ((state==IDLE & ~gap_q) | state==DATA | state==DROP).
- **States**
  - IDLE: emit an all-idle word (ctrl_v=idle_v=4'hF, data=0, keep=0). Clear gap_q. If s_valid_i and ~gap_q, accept beat 0 and emit the start word:
    - lane 0: start_v[0]=1, ctrl_v[0]=1, data=64'hD555_5555_5555_55FB, keep=8'hFF.
    - lanes 1-3: beat bytes 0..23.
    - residue register := bytes 24..31.
  - DATA: each accepted beat produces lane 0 = residue, lanes 1-3 = beat bytes 0..23. Residue := bytes 24..31.
- **Last beat**, k = popcount(s_keep_i), B = 8 + k valid bytes in the word:
  - k<24: term lane t=B/8 gets term_v, ctrl_v, data = valid bytes (upper bytes zero), keep = (1<<(B%8))-1. Lanes above t are idle. Go to IDLE with gap_q=1.
  - k>=24: all 4 lanes carry data. Go to FLUSH.
- **Single-beat frame**: lane 0 holds the preamble instead of the residue; the same B rule applies.
- **FLUSH**: no input accepted. Emit residue bytes k-24 (0..8) then terminate:
  - k-24<8: lane 0 = term with keep=(1<<(k-24))-1; lanes 1-3 idle.
  - k=32: lane 0 = data 0xFF; lane 1 = term with keep 0; lanes 2-3 idle.
  - Then IDLE with gap_q=1.
- **Error**: if s_err_i=1 on the last beat, the term lane is replaced by an error block (err_v=1, ctrl_v=1, term_v=0, data=0, keep=0).
- **Underrun**: s_valid_i=0 in DATA while pcs_ready_i=1.
  - Emit lane 0 = error block, lanes 1-3 idle.
  - Go to DROP. DROP accepts and discards beats up to and including s_last_i, emitting idle words, then IDLE with gap_q=1.
- A lane is never flagged both data and control. data/keep of idle and error lanes are zero.

## Timing
- Reset: state IDLE, gap_q=1, residue=0, ctrl_v_o=idle_v_o=4'hF, start/term/err_v_o=0, data_o=0, keep_o=0. s_ready_o=0 in the first cycle after reset.
- Latency: a beat accepted at edge n appears on outputs after edge n; the last beat of a k>=24 frame adds one FLUSH word.
- Throughput: one beat per cycle with pcs_ready_i=1. Frame overhead is one start lane, one flush word when k>=24, and at least one all-idle word.
- pcs_ready_i=0: no input accepted, no state change, outputs stable. Any cycle count is allowed, including mid-frame; underrun is not declared.
- s_valid_i=0 during IDLE is not an error.
- Reset mid-frame: aborts with no terminate; outputs idle from the next cycle.

## Test plan
- **Single-beat frame**: k=16, pcs_ready_i=1 -> word0: lane0 start FB/55/D5; lanes1-2 data; lane3 term keep 0x00. word1: all idle. Next frame's start no earlier than word2.
- **Two-beat frame**: beat1 k=32 -> FLUSH word: lane0 data keep 0xFF, lane1 term keep 0x00, lanes2-3 idle.
- **Two-beat frame**: beat1 k=27 -> FLUSH word: lane0 term keep 0x07.
- **Back-pressure**: pcs_ready_i low 3 cycles mid-frame -> outputs frozen, s_ready_o=0; stream resumes byte-exact with no error.
- **Error**: s_err_i=1 on last beat k=5 -> lane1 err_v=1, term_v=0.
- **Underrun**: s_valid_i=0 after beat 1 of a 4-beat frame -> error block on lane0; remaining 2 beats dropped; next frame starts cleanly after one idle word.
